fft_output_serializer: RTL
==========================

FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 SHALL have parameter formatWidth, default 9, width of one float sample (1 sign, 4 exp, 4 sig).
REQ-002 SHALL have parameter LANES, default 32, number of samples per FFT result vector; power of two.
REQ-003 SHALL have parameter BITREV, default 1; 1 = emit samples in bit-reversed lane order, 0 = natural lane order.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port fft_done  input  1  FFT completion level; a 0->1 transition marks a valid result vector.
REQ-007 SHALL have port output_real  input  formatWidth*LANES  FFT real results; lane k at bits [formatWidth*(k+1)-1 : formatWidth*k].
REQ-008 SHALL have port output_imag  input  formatWidth*LANES  FFT imaginary results; same lane packing.
REQ-009 SHALL have port out_real  output  formatWidth  serialized real sample.
REQ-010 SHALL have port out_imag  output  formatWidth  serialized imaginary sample.
REQ-011 SHALL have port out_index  output  log2(LANES)  frequency-bin index of the current sample.
REQ-012 SHALL have port out_valid  output  1  sample on out_* is valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-014 SHALL have port out_last  output  1  high with the final sample (out_index = LANES-1) of a frame.
REQ-015 SHALL have port busy  output  1  high while a frame is held or streaming.
REQ-016 SHALL have port overrun  output  1  one-cycle pulse when a result vector is dropped.

Function
REQ-017 SHALL register fft_done into done_d each cycle; capture event = fft_done & ~done_d.
REQ-018 SHALL use FSM states IDLE and SEND.
REQ-019 In IDLE, a capture event SHALL latch output_real/output_imag into an internal buffer, clear the index counter to 0, and enter SEND on the same edge.
REQ-020 out_valid and busy SHALL be 1 exactly while in SEND; first sample visible the cycle after the capture edge (latency 1).
REQ-021 A transfer SHALL occur on an edge where out_valid & out_ready; the index counter increments by 1 per transfer.
REQ-022 out_index SHALL equal the counter i; out_real/out_imag SHALL be buffer lane bitrev(i) when BITREV=1, lane i when BITREV=0.
REQ-023 While out_valid & ~out_ready, out_real, out_imag, out_index, and out_last SHALL hold stable.
REQ-024 out_last SHALL be 1 iff in SEND and i = LANES-1.
REQ-025 On the transfer with out_last=1 and no simultaneous capture event, FSM SHALL return to IDLE; the counter wraps to 0.
REQ-026 A capture event coinciding with the last transfer SHALL latch the new vector, set i=0, and remain in SEND; overrun stays 0.
REQ-027 A capture event in SEND other than per REQ-026 SHALL leave the buffer and counter unchanged and pulse overrun for one cycle.
REQ-028 fft_done held high for many cycles SHALL produce only one capture event.
REQ-029 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL set: FSM=IDLE, counter=0, buffer=0, out_valid=0, out_last=0, busy=0, overrun=0, out_real=0, out_imag=0, out_index=0.
REQ-031 Reset SHALL set done_d=1, so fft_done held high through reset release does not generate a capture event.
REQ-032 Reset asserted mid-frame SHALL abort the frame; no further samples of that frame are emitted.

Verification
REQ-033 Ramp: lane k real=k, imag=31-k, BITREV=1, out_ready=1, pulse fft_done -> 32 consecutive beats starting 1 cycle after the edge; beat i real=bitrev5(i) (beat 1 = 16, beat 2 = 8); out_last only on beat 31.
REQ-034 Same stimulus with BITREV=0 and out_ready toggling 1,0,1,0 -> real sequence 0..31 with no repeats or skips; outputs are stable during ready-low cycles.
REQ-035 Second fft_done rising edge at beat 10 -> overrun=1 for exactly one cycle; remaining beats still come from the first vector.
REQ-036 Second rising edge on the same cycle as the beat-31 transfer -> next cycle out_valid=1, out_index=0, with new vector data; overrun=0.
REQ-037 rst=1 at beat 5 while fft_done is held high, then released -> all outputs 0; no capture until fft_done falls and rises again.
REQ-038 fft_done held high for 100 cycles with out_ready=1 -> exactly 32 beats; busy falls after beat 31.

Source files
------------

// File: rtl/fft_output_serializer.sv
// Serializes one captured FFT result vector into a valid/ready stream of
// (real, imag, bin index) samples, optionally in bit-reversed lane order.
module fft_output_serializer #(
  parameter int formatWidth = 9,
  parameter int LANES       = 32,
  parameter int BITREV      = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               fft_done,
  input  logic [formatWidth*LANES-1:0]       output_real,
  input  logic [formatWidth*LANES-1:0]       output_imag,
  output logic [formatWidth-1:0]             out_real,
  output logic [formatWidth-1:0]             out_imag,
  output logic [$clog2(LANES)-1:0]           out_index,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               overrun
);

  localparam int IW = $clog2(LANES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nx;
  logic                   done_d;
  logic                   cap;
  logic                   xfer;
  logic                   last;
  logic                   load;
  logic                   ovr_nx;
  logic [IW-1:0]          idx, idx_nx;
  logic [IW-1:0]          idx_rev;
  logic [IW-1:0]          lane_sel;
  logic [formatWidth-1:0] buf_real [LANES];
  logic [formatWidth-1:0] buf_imag [LANES];

  assign cap  = fft_done & ~done_d;
  assign last = (state == SEND) && (idx == IW'(LANES - 1));
  assign xfer = (state == SEND) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A capture on the final transfer chains straight into the next frame;
  // any other capture while sending is dropped and flagged.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    ovr_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          load     = 1'b1;
          idx_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (xfer && last) begin
          idx_nx = '0;
          if (cap) load = 1'b1;
          else     state_nx = IDLE;
        end else begin
          if (xfer) idx_nx = idx + 1'b1;
          if (cap)  ovr_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_d  <= 1'b1;
      idx     <= '0;
      overrun <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        buf_real[k] <= '0;
        buf_imag[k] <= '0;
      end
    end else begin
      done_d  <= fft_done;
      idx     <= idx_nx;
      overrun <= ovr_nx;
      if (load) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          buf_real[k] <= output_real[k*formatWidth +: formatWidth];
          buf_imag[k] <= output_imag[k*formatWidth +: formatWidth];
        end
      end
    end
  end

  always_comb begin
    idx_rev = '0;
    for (int unsigned b = 0; b < IW; b++) idx_rev[b] = idx[IW-1-b];
  end

  assign lane_sel  = (BITREV != 0) ? idx_rev : idx;
  assign out_real  = buf_real[lane_sel];
  assign out_imag  = buf_imag[lane_sel];
  assign out_index = idx;
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_last  = last;

endmodule
